// File: rtl/instr_register_alu.sv
// instr_register_alu: DEPTH-entry instruction store whose result field is computed before commit.
// Non-divide ops use a fixed 2-stage pipeline; DIV/MOD use an iterative divider that stalls writes.
module instr_register_alu #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned OP_W  = 32,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned RES_W = 2 * OP_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_en,
    input  logic [AW-1:0]    write_pointer,
    input  logic [2:0]       opcode,
    input  logic [OP_W-1:0]  operand_a,
    input  logic [OP_W-1:0]  operand_b,
    output logic             wr_ready,
    input  logic             read_en,
    input  logic [AW-1:0]    read_pointer,
    output logic             rd_valid,
    output logic             rd_hit,
    output logic [2:0]       rd_opcode,
    output logic [OP_W-1:0]  rd_op_a,
    output logic [OP_W-1:0]  rd_op_b,
    output logic [RES_W-1:0] rd_result,
    output logic             rd_err,
    output logic [AW:0]      entry_count
);

    localparam int unsigned CW = $clog2(OP_W);

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;

    function automatic logic [OP_W-1:0] mag(input logic [OP_W-1:0] v);
        mag = v[OP_W-1] ? (~v + OP_W'(1)) : v;
    endfunction

    // Stage 1: captured request (held for the whole divide)
    logic            s1_valid_q, s1_valid_d;
    logic [2:0]      s1_op_q, s1_op_d;
    logic [OP_W-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    logic [AW-1:0]   s1_ptr_q, s1_ptr_d;

    // Stage 2: computed entry waiting to commit
    logic             s2_valid_q, s2_valid_d;
    logic [2:0]       s2_op_q, s2_op_d;
    logic [OP_W-1:0]  s2_a_q, s2_a_d, s2_b_q, s2_b_d;
    logic [AW-1:0]    s2_ptr_q, s2_ptr_d;
    logic [RES_W-1:0] s2_res_q, s2_res_d;
    logic             s2_err_q, s2_err_d;

    // Divider state: unsigned restoring divide on operand magnitudes
    logic            div_run_q, div_run_d;
    logic            div_done_q, div_done_d;
    logic [CW-1:0]   div_cnt_q, div_cnt_d;
    logic [OP_W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic            wr_ready_q, wr_ready_d;

    // Storage and read port
    logic [2:0]       mem_op_q  [DEPTH];
    logic [OP_W-1:0]  mem_a_q   [DEPTH];
    logic [OP_W-1:0]  mem_b_q   [DEPTH];
    logic [RES_W-1:0] mem_res_q [DEPTH];
    logic [DEPTH-1:0] mem_err_q;
    logic [DEPTH-1:0] valid_q;
    logic [AW:0]      count_q;

    logic             rd_valid_q, rd_hit_q, rd_err_q;
    logic [2:0]       rd_op_q;
    logic [OP_W-1:0]  rd_a_q, rd_b_q;
    logic [RES_W-1:0] rd_res_q;

    logic                    accept;
    logic                    s1_is_div;
    logic signed [RES_W-1:0] a_ext, b_ext, alu_res;
    logic [RES_W-1:0]        div_res;
    logic [OP_W:0]           rem_sh;

    assign accept    = load_en && wr_ready_q;
    assign s1_is_div = (s1_op_q[2:1] == 2'b11);
    assign a_ext     = {{OP_W{s1_a_q[OP_W-1]}}, s1_a_q};
    assign b_ext     = {{OP_W{s1_b_q[OP_W-1]}}, s1_b_q};
    assign rem_sh    = {rem_q, quo_q[OP_W-1]};

    always_comb begin
        case (s1_op_q)
            OP_ZERO:  alu_res = '0;
            OP_PASSA: alu_res = a_ext;
            OP_PASSB: alu_res = b_ext;
            OP_ADD:   alu_res = a_ext + b_ext;
            OP_SUB:   alu_res = a_ext - b_ext;
            OP_MULT:  alu_res = a_ext * b_ext;
            default:  alu_res = '0;
        endcase
    end

    // Sign fix-up: quotient truncates toward zero, remainder follows the dividend
    always_comb begin
        if (s1_b_q == '0) begin
            div_res = '0;
        end else if (s1_op_q == OP_DIV) begin
            div_res = (s1_a_q[OP_W-1] ^ s1_b_q[OP_W-1]) ? -RES_W'(quo_q) : RES_W'(quo_q);
        end else begin
            div_res = s1_a_q[OP_W-1] ? -RES_W'(rem_q) : RES_W'(rem_q);
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_op_d    = s1_op_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_ptr_d   = s1_ptr_q;
        s2_valid_d = 1'b0;
        s2_op_d    = s2_op_q;
        s2_a_d     = s2_a_q;
        s2_b_d     = s2_b_q;
        s2_ptr_d   = s2_ptr_q;
        s2_res_d   = s2_res_q;
        s2_err_d   = s2_err_q;
        div_run_d  = div_run_q;
        div_done_d = 1'b0;
        div_cnt_d  = div_cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        wr_ready_d = wr_ready_q;

        if ((s1_valid_q && !s1_is_div) || div_done_q) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b1;
            s2_op_d    = s1_op_q;
            s2_a_d     = s1_a_q;
            s2_b_d     = s1_b_q;
            s2_ptr_d   = s1_ptr_q;
            s2_res_d   = div_done_q ? div_res : RES_W'(alu_res);
            s2_err_d   = div_done_q && (s1_b_q == '0);
        end

        if (div_run_q) begin
            if (rem_sh >= {1'b0, dvs_q}) begin
                rem_d = OP_W'(rem_sh - {1'b0, dvs_q});
                quo_d = {quo_q[OP_W-2:0], 1'b1};
            end else begin
                rem_d = rem_sh[OP_W-1:0];
                quo_d = {quo_q[OP_W-2:0], 1'b0};
            end
            div_cnt_d = div_cnt_q + CW'(1);
            if (div_cnt_q == CW'(OP_W - 1)) begin
                div_run_d  = 1'b0;
                div_done_d = 1'b1;
                wr_ready_d = 1'b1;
            end
        end

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_op_d    = opcode;
            s1_a_d     = operand_a;
            s1_b_d     = operand_b;
            s1_ptr_d   = write_pointer;
            if (opcode[2:1] == 2'b11) begin
                div_run_d  = 1'b1;
                div_cnt_d  = '0;
                rem_d      = '0;
                quo_d      = mag(operand_a);
                dvs_d      = mag(operand_b);
                wr_ready_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= '0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ptr_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_op_q    <= '0;
            s2_a_q     <= '0;
            s2_b_q     <= '0;
            s2_ptr_q   <= '0;
            s2_res_q   <= '0;
            s2_err_q   <= 1'b0;
            div_run_q  <= 1'b0;
            div_done_q <= 1'b0;
            div_cnt_q  <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            wr_ready_q <= 1'b1;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_op_q    <= s1_op_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_ptr_q   <= s1_ptr_d;
            s2_valid_q <= s2_valid_d;
            s2_op_q    <= s2_op_d;
            s2_a_q     <= s2_a_d;
            s2_b_q     <= s2_b_d;
            s2_ptr_q   <= s2_ptr_d;
            s2_res_q   <= s2_res_d;
            s2_err_q   <= s2_err_d;
            div_run_q  <= div_run_d;
            div_done_q <= div_done_d;
            div_cnt_q  <= div_cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            wr_ready_q <= wr_ready_d;
        end
    end

    // Commit: count only first-time writes to an entry
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_op_q[i]  <= '0;
                mem_a_q[i]   <= '0;
                mem_b_q[i]   <= '0;
                mem_res_q[i] <= '0;
            end
            mem_err_q <= '0;
            valid_q   <= '0;
            count_q   <= '0;
        end else if (s2_valid_q) begin
            mem_op_q[s2_ptr_q]  <= s2_op_q;
            mem_a_q[s2_ptr_q]   <= s2_a_q;
            mem_b_q[s2_ptr_q]   <= s2_b_q;
            mem_res_q[s2_ptr_q] <= s2_res_q;
            mem_err_q[s2_ptr_q] <= s2_err_q;
            valid_q[s2_ptr_q]   <= 1'b1;
            if (!valid_q[s2_ptr_q]) begin
                count_q <= count_q + (AW+1)'(1);
            end
        end
    end

    // Read port with write-through of a same-edge commit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
            rd_op_q    <= '0;
            rd_a_q     <= '0;
            rd_b_q     <= '0;
            rd_res_q   <= '0;
            rd_err_q   <= 1'b0;
        end else begin
            rd_valid_q <= read_en;
            if (read_en) begin
                if (s2_valid_q && (s2_ptr_q == read_pointer)) begin
                    rd_hit_q <= 1'b1;
                    rd_op_q  <= s2_op_q;
                    rd_a_q   <= s2_a_q;
                    rd_b_q   <= s2_b_q;
                    rd_res_q <= s2_res_q;
                    rd_err_q <= s2_err_q;
                end else if (valid_q[read_pointer]) begin
                    rd_hit_q <= 1'b1;
                    rd_op_q  <= mem_op_q[read_pointer];
                    rd_a_q   <= mem_a_q[read_pointer];
                    rd_b_q   <= mem_b_q[read_pointer];
                    rd_res_q <= mem_res_q[read_pointer];
                    rd_err_q <= mem_err_q[read_pointer];
                end else begin
                    rd_hit_q <= 1'b0;
                    rd_op_q  <= '0;
                    rd_a_q   <= '0;
                    rd_b_q   <= '0;
                    rd_res_q <= '0;
                    rd_err_q <= 1'b0;
                end
            end
        end
    end

    assign wr_ready    = wr_ready_q;
    assign rd_valid    = rd_valid_q;
    assign rd_hit      = rd_hit_q;
    assign rd_opcode   = rd_op_q;
    assign rd_op_a     = rd_a_q;
    assign rd_op_b     = rd_b_q;
    assign rd_result   = rd_res_q;
    assign rd_err      = rd_err_q;
    assign entry_count = count_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// Self-checking bench for instr_register_alu: vector table plus latency/stall/reset sequences.
module tb_instr_register_alu;

    localparam int unsigned OP_W  = 32;
    localparam int unsigned RES_W = 64;
    localparam int unsigned AW    = 5;

    localparam logic [2:0] OP_ZERO  = 3'd0;
    localparam logic [2:0] OP_PASSA = 3'd1;
    localparam logic [2:0] OP_PASSB = 3'd2;
    localparam logic [2:0] OP_ADD   = 3'd3;
    localparam logic [2:0] OP_SUB   = 3'd4;
    localparam logic [2:0] OP_MULT  = 3'd5;
    localparam logic [2:0] OP_DIV   = 3'd6;
    localparam logic [2:0] OP_MOD   = 3'd7;

    localparam logic [OP_W-1:0] MIN_A = 32'h8000_0000;

    logic             clk = 1'b0;
    logic             reset_n, load_en, read_en;
    logic [AW-1:0]    write_pointer, read_pointer;
    logic [2:0]       opcode;
    logic [OP_W-1:0]  operand_a, operand_b;
    logic             wr_ready, rd_valid, rd_hit, rd_err;
    logic [2:0]       rd_opcode;
    logic [OP_W-1:0]  rd_op_a, rd_op_b;
    logic [RES_W-1:0] rd_result;
    logic [AW:0]      entry_count;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [2:0]       op;
        logic [OP_W-1:0]  a;
        logic [OP_W-1:0]  b;
        logic [AW-1:0]    ptr;
        logic [RES_W-1:0] res;
        logic             err;
    } vec_t;

    vec_t tv [14];

    always #5 clk = ~clk;

    instr_register_alu dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .load_en       (load_en),
        .write_pointer (write_pointer),
        .opcode        (opcode),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .wr_ready      (wr_ready),
        .read_en       (read_en),
        .read_pointer  (read_pointer),
        .rd_valid      (rd_valid),
        .rd_hit        (rd_hit),
        .rd_opcode     (rd_opcode),
        .rd_op_a       (rd_op_a),
        .rd_op_b       (rd_op_b),
        .rd_result     (rd_result),
        .rd_err        (rd_err),
        .entry_count   (entry_count)
    );

    function automatic vec_t mk(input logic [2:0] op, input logic [OP_W-1:0] a,
                                input logic [OP_W-1:0] b, input logic [AW-1:0] ptr,
                                input logic [RES_W-1:0] res, input logic err);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.ptr = ptr; v.res = res; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) chk("ready_timeout", 64'(wr_ready), 64'd1);
    endtask

    task automatic drive_wr(input logic [2:0] op, input logic [OP_W-1:0] a,
                            input logic [OP_W-1:0] b, input logic [AW-1:0] ptr);
        load_en = 1'b1; opcode = op; operand_a = a; operand_b = b; write_pointer = ptr;
    endtask

    task automatic read_entry(input logic [AW-1:0] ptr);
        read_en = 1'b1; read_pointer = ptr;
        @(negedge clk);
        read_en = 1'b0;
    endtask

    // Read one edge before and exactly at the commit edge of a pipelined op
    task automatic pipe_seq(input string name, input logic [2:0] op, input logic [OP_W-1:0] a,
                            input logic [OP_W-1:0] b, input logic [AW-1:0] ptr,
                            input logic [RES_W-1:0] exp);
        drive_wr(op, a, b, ptr);
        @(negedge clk);
        load_en = 1'b0; read_en = 1'b1; read_pointer = ptr;
        chk({name, "_ready_high"}, 64'(wr_ready), 64'd1);
        @(negedge clk);
        chk({name, "_early_valid"}, 64'(rd_valid), 64'd1);
        chk({name, "_early_hit"}, 64'(rd_hit), 64'd0);
        chk({name, "_early_result"}, rd_result, 64'd0);
        chk({name, "_early_opcode"}, 64'(rd_opcode), 64'd0);
        @(negedge clk);
        read_en = 1'b0;
        chk({name, "_valid"}, 64'(rd_valid), 64'd1);
        chk({name, "_hit"}, 64'(rd_hit), 64'd1);
        chk({name, "_result"}, rd_result, exp);
        chk({name, "_err"}, 64'(rd_err), 64'd0);
    endtask

    // DIV/MOD: count stall cycles, push ignored writes, read before/at commit
    task automatic div_seq(input string name, input logic [2:0] op, input logic [OP_W-1:0] a,
                           input logic [OP_W-1:0] b, input logic [AW-1:0] ptr,
                           input logic [RES_W-1:0] exp, input logic exp_err);
        int lows = 0;
        wait_ready();
        drive_wr(op, a, b, ptr);
        @(negedge clk);
        for (int j = 0; j < 40; j++) begin
            if (wr_ready) break;
            lows++;
            if (j == 0) drive_wr(OP_ADD, 32'h55, 32'h1, 5'd29);
            @(negedge clk);
        end
        load_en = 1'b0; read_en = 1'b1; read_pointer = ptr;
        chk({name, "_stall_cycles"}, 64'(lows), 64'd32);
        @(negedge clk);
        chk({name, "_early_hit"}, 64'(rd_hit), 64'd0);
        @(negedge clk);
        read_en = 1'b0;
        chk({name, "_hit"}, 64'(rd_hit), 64'd1);
        chk({name, "_result"}, rd_result, exp);
        chk({name, "_err"}, 64'(rd_err), 64'(exp_err));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; load_en = 1'b0; read_en = 1'b0;
        write_pointer = '0; read_pointer = '0; opcode = '0;
        operand_a = '0; operand_b = '0;

        tv[0]  = mk(OP_ADD,   -32'sd7,       32'sd5,        5'd10, -64'sd2,                    1'b0);
        tv[1]  = mk(OP_SUB,   32'sd10,       32'sd3,        5'd11, 64'sd7,                     1'b0);
        tv[2]  = mk(OP_PASSA, -32'sd100,     32'sd9,        5'd12, -64'sd100,                  1'b0);
        tv[3]  = mk(OP_PASSB, 32'sd1,        -32'sd1,       5'd13, -64'sd1,                    1'b0);
        tv[4]  = mk(OP_ZERO,  32'sd5,        32'sd6,        5'd14, 64'sd0,                     1'b0);
        tv[5]  = mk(OP_MULT,  MIN_A,         -32'sd1,       5'd31, 64'sd2147483648,            1'b0);
        tv[6]  = mk(OP_MULT,  32'sd123456,   -32'sd654321,  5'd15, -64'sd80779853376,          1'b0);
        tv[7]  = mk(OP_MULT,  32'h7fff_ffff, 32'h7fff_ffff, 5'd16, 64'sd4611686014132420609,   1'b0);
        tv[8]  = mk(OP_ADD,   32'h7fff_ffff, 32'sd1,        5'd17, 64'sd2147483648,            1'b0);
        tv[9]  = mk(OP_SUB,   MIN_A,         32'sd1,        5'd18, -64'sd2147483649,           1'b0);
        tv[10] = mk(OP_DIV,   32'sd7,        -32'sd2,       5'd19, -64'sd3,                    1'b0);
        tv[11] = mk(OP_MOD,   32'sd17,       -32'sd5,       5'd20, 64'sd2,                     1'b0);
        tv[12] = mk(OP_MOD,   -32'sd8,       32'sd0,        5'd21, 64'sd0,                     1'b1);
        tv[13] = mk(OP_DIV,   MIN_A,         32'sd1,        5'd22, -64'sd2147483648,           1'b0);

        do_reset();
        chk("reset_wr_ready", 64'(wr_ready), 64'd1);
        chk("reset_rd_valid", 64'(rd_valid), 64'd0);
        chk("reset_rd_hit", 64'(rd_hit), 64'd0);
        chk("reset_rd_result", rd_result, 64'd0);
        chk("reset_count", 64'(entry_count), 64'd0);

        pipe_seq("add_e3", OP_ADD, -32'sd7, 32'sd5, 5'd3, -64'sd2);
        chk("count_after_add", 64'(entry_count), 64'd1);
        pipe_seq("sub_e5", OP_SUB, 32'sd10, 32'sd3, 5'd5, 64'sd7);
        chk("count_after_sub", 64'(entry_count), 64'd2);

        for (int i = 0; i < 14; i++) begin
            wait_ready();
            drive_wr(tv[i].op, tv[i].a, tv[i].b, tv[i].ptr);
            @(negedge clk);
            load_en = 1'b0;
            wait_ready();
            repeat (2) @(negedge clk);
            read_entry(tv[i].ptr);
            chk($sformatf("vec%0d_valid", i), 64'(rd_valid), 64'd1);
            chk($sformatf("vec%0d_hit", i), 64'(rd_hit), 64'd1);
            chk($sformatf("vec%0d_opcode", i), 64'(rd_opcode), 64'(tv[i].op));
            chk($sformatf("vec%0d_op_a", i), 64'(rd_op_a), 64'(tv[i].a));
            chk($sformatf("vec%0d_op_b", i), 64'(rd_op_b), 64'(tv[i].b));
            chk($sformatf("vec%0d_result", i), rd_result, tv[i].res);
            chk($sformatf("vec%0d_err", i), 64'(rd_err), 64'(tv[i].err));
        end
        chk("count_after_table", 64'(entry_count), 64'd16);

        div_seq("div_min", OP_DIV, MIN_A, -32'sd1, 5'd30, 64'sd2147483648, 1'b0);
        div_seq("div_neg", OP_DIV, -32'sd17, 32'sd5, 5'd24, -64'sd3, 1'b0);
        div_seq("mod_neg", OP_MOD, -32'sd17, 32'sd5, 5'd25, -64'sd2, 1'b0);
        div_seq("div_zero", OP_DIV, 32'sd9, 32'sd0, 5'd26, 64'sd0, 1'b1);
        read_entry(5'd29);
        chk("stalled_write_ignored", 64'(rd_hit), 64'd0);
        chk("count_after_div", 64'(entry_count), 64'd20);

        // Non-divide accept on the first ready edge after a DIV commits behind it
        wait_ready();
        drive_wr(OP_DIV, 32'sd100, 32'sd7, 5'd27);
        @(negedge clk);
        load_en = 1'b0;
        wait_ready();
        drive_wr(OP_ADD, 32'sd1, 32'sd1, 5'd27);
        read_en = 1'b1; read_pointer = 5'd27;
        @(negedge clk);
        load_en = 1'b0;
        chk("order_pre_hit", 64'(rd_hit), 64'd0);
        @(negedge clk);
        chk("order_div_result", rd_result, 64'd14);
        @(negedge clk);
        read_en = 1'b0;
        chk("order_add_result", rd_result, 64'd2);
        chk("order_count", 64'(entry_count), 64'd21);

        // Fill every entry, then two back-to-back rewrites of entry 0
        do_reset();
        for (int i = 0; i < 32; i++) begin
            drive_wr(OP_PASSA, 32'(1000 + i), 32'd0, 5'(i));
            @(negedge clk);
        end
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("fill_count", 64'(entry_count), 64'd32);
        drive_wr(OP_PASSA, 32'd100, 32'd0, 5'd0);
        @(negedge clk);
        drive_wr(OP_PASSA, 32'd200, 32'd0, 5'd0);
        @(negedge clk);
        load_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("rewrite_count", 64'(entry_count), 64'd32);
        read_entry(5'd0);
        chk("rewrite_last_wins", rd_result, 64'd200);
        read_entry(5'd17);
        chk("fill_entry17", rd_result, 64'd1017);

        // Reset ten cycles into a DIV drops it and a pending read
        do_reset();
        drive_wr(OP_DIV, 32'sd100, 32'sd7, 5'd9);
        @(negedge clk);
        load_en = 1'b0;
        repeat (9) @(negedge clk);
        chk("middiv_busy", 64'(wr_ready), 64'd0);
        reset_n = 1'b0; read_en = 1'b1; read_pointer = 5'd9;
        @(negedge clk);
        reset_n = 1'b1; read_en = 1'b0;
        chk("postreset_ready", 64'(wr_ready), 64'd1);
        chk("postreset_count", 64'(entry_count), 64'd0);
        chk("postreset_rd_valid", 64'(rd_valid), 64'd0);
        repeat (40) @(negedge clk);
        chk("dropped_count", 64'(entry_count), 64'd0);
        read_entry(5'd9);
        chk("dropped_valid", 64'(rd_valid), 64'd1);
        chk("dropped_hit", 64'(rd_hit), 64'd0);
        chk("dropped_result", rd_result, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_register_alu.md
# instr_register_alu

Parametrised successor of the lab instruction register: a DEPTH-entry store of {opcode, operand_a, operand_b, result, err}, where the result is computed in hardware before commit. ADD/SUB/PASS/ZERO/MULT go through a fixed 2-stage pipeline. DIV/MOD use an iterative signed divider that back-pressures the write port. It sits between the test/stimulus side and any consumer of computed instruction words, replacing the single-cycle register.

## Interface
- DEPTH, 32, number of entries; power of two, >= 2; AW = $clog2(DEPTH)
- OP_W, 32, signed operand width; >= 4
- RES_W, 2*OP_W, signed result width; fixed at 2*OP_W
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- load_en  in  1  write request
- write_pointer  in  AW  destination entry
- opcode  in  3  ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7
- operand_a, operand_b  in  OP_W each  signed operands
- wr_ready  out  1  write accepted on an edge where load_en && wr_ready
- read_en  in  1  read request
- read_pointer  in  AW  entry to read
- rd_valid  out  1  read data valid; 1-cycle pulse
- rd_hit  out  1  entry has been committed since reset
- rd_opcode / rd_op_a / rd_op_b / rd_result / rd_err  out  3 / OP_W / OP_W / RES_W / 1  stored entry
- entry_count  out  AW+1  number of entries with valid bit set

## Operation
- Accept at edge E0 captures {opcode, operands, write_pointer} into stage 1.
- Non-divide ops:
  - Result registered at E0+1; committed to array at E0+2.
  - One accept per cycle; wr_ready stays 1.
- DIV/MOD:
  - Divider runs OP_W iterations.
  - wr_ready is 0 for the OP_W cycles after E0 and returns to 1 in the cycle after that.
  - Commit at E0+OP_W+2.
  - In-order commit is guaranteed because nothing is accepted while the divider is busy.
- Arithmetic (all operands sign-extended to RES_W):
  - ZERO = 0; PASSA = a; PASSB = b; ADD = a+b; SUB = a-b.
  - MULT = full signed product.
  - DIV truncates toward zero. MOD takes the sign of the dividend (matches SV / and %).
  - Most negative / -1 yields +2^(OP_W-1); no overflow at RES_W.
- Divide-by-zero (DIV or MOD with b=0): result 0, err=1. All other ops have err=0.
  - The zero-divisor case still takes the full OP_W-cycle latency.
- Commit:
  - Writes the entry and sets its valid bit.
  - entry_count increments only if the valid bit was previously 0.
  - Overwriting a valid entry leaves the count unchanged; count saturates naturally at DEPTH.
- Read:
  - read_en at edge R latches the entry into the output registers; rd_valid=1 in the following cycle.
  - Write-through: a commit to the same address at edge R is returned (new data).
  - In-flight, uncommitted writes are not visible.
  - An invalid entry returns rd_hit=0 with all data fields 0.
- load_en while wr_ready=0 is ignored; no capture, no error.
- Reads and writes are independent. A read is allowed on any cycle, including while the divider is busy.

## Timing
- Reset (reset_n=0 sampled at an edge), effective that edge:
  - Outputs: wr_ready=1, rd_valid=0, rd_hit=0, rd_* = 0, entry_count=0.
  - All valid bits and entry contents cleared.
  - Pipeline and divider flushed.
- Reset mid-operation: in-flight writes (pipeline or divider) are dropped and never committed. A pending read produces no rd_valid.
- The first accept is legal on the first edge with reset_n=1.
- Accept-to-visible latency:
  - Non-divide: a read sampled at E0+2 or later returns the new data.
  - DIV/MOD: a read sampled at E0+OP_W+2 or later returns the new data.
- Back-to-back non-divide writes to the same address commit on consecutive edges; the later one wins.
- A non-divide accept at cycle E0+OP_W+1 after a DIV is legal. Its commit (E0+OP_W+3) follows the DIV commit.
- rd_valid stays high on consecutive cycles when read_en is held high.

## Test plan
- Reset, then write ADD a=-7 b=5 to entry 3; read at E0+2 -> rd_valid=1, rd_hit=1, rd_result=-2, rd_err=0, entry_count=1.
- MULT a=-2147483648 b=-1 to entry 31 -> rd_result=2147483648 (64-bit). Then DIV with the same operands to entry 30 -> rd_result=2147483648, err=0.
- DIV a=-17 b=5 -> -3; MOD a=-17 b=5 -> -2; DIV a=9 b=0 -> result 0, err=1.
  - For each: wr_ready is low for exactly 32 cycles, and load_en pulses during that window are ignored.
- Write all 32 entries, then rewrite entry 0 -> entry_count=32 and stays 32. Read of entry 0 returns the rewrite; consecutive commits to the same address keep the last value.
- Same-edge read and commit to entry 5 (SUB 10-3) -> read returns 7. A read one edge earlier returns rd_hit=0, zeros.
- Assert reset_n=0 for one edge, 10 cycles into a DIV -> no commit after release, entry_count=0, wr_ready=1 on the first cycle after reset. A subsequent read of that entry returns rd_hit=0.
